// File: rtl/mcu_core_param_if.sv
// Program-load and output port bundle for mcu_core_param.
// The host drives the master side and the core sits on the slave side.
interface mcu_core_param_if #(
    parameter int DW  = 8,
    parameter int PAW = 4
);
    localparam int IW = DW + 4;

    logic           ld_valid;
    logic [IW-1:0]  ld_data;
    logic           ld_last;
    logic           ld_ready;
    logic           reload;
    logic [DW-1:0]  out_data;
    logic           out_valid;
    logic [PAW-1:0] pc;
    logic           halted;

    modport master (
        output ld_valid, ld_data, ld_last, reload,
        input  ld_ready, out_data, out_valid, pc, halted
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, reload,
        output ld_ready, out_data, out_valid, pc, halted
    );
endinterface

// File: rtl/mcu_core_param.sv
// Parametrised multi-cycle accumulator core: streamed program load, then a
// 3-cycle fetch/decode/execute loop until HLT; reload returns to LOAD.
module mcu_core_param #(
    parameter int DW  = 8,
    parameter int PAW = 4,
    parameter int DAW = 4
) (
    input  logic           clk,
    input  logic           rs,
    mcu_core_param_if.slave bus
);
    localparam int IW = DW + 4;

    localparam logic [2:0] S_LOAD   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LDM  = 4'h2;
    localparam logic [3:0] OP_STM  = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_ADDM = 4'h5;
    localparam logic [3:0] OP_SUBM = 4'h6;
    localparam logic [3:0] OP_ANDM = 4'h7;
    localparam logic [3:0] OP_ORM  = 4'h8;
    localparam logic [3:0] OP_XORM = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_OUT  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    logic [2:0]     state;
    logic [PAW-1:0] load_addr;
    logic [PAW-1:0] pc;
    logic [DW-1:0]  acc;
    logic [DW-1:0]  dr;
    logic [IW-1:0]  ir;
    logic           flag_n, flag_c, flag_z;
    logic [DW-1:0]  out_data;
    logic           out_valid;

    logic [IW-1:0]  pmem [2**PAW];
    logic [DW-1:0]  dmem [2**DAW];

    logic [3:0]     opcode;
    logic [DW-1:0]  k;
    logic [DAW-1:0] daddr;
    logic           load_fire, load_done;

    assign opcode    = ir[IW-1:DW];
    assign k         = ir[DW-1:0];
    assign daddr     = ir[DAW-1:0];
    assign load_fire = (state == S_LOAD) && bus.ld_valid;
    // A full program memory ends the load even without ld_last.
    assign load_done = load_fire && (bus.ld_last || (&load_addr));

    assign bus.ld_ready  = (state == S_LOAD);
    assign bus.halted    = (state == S_HALT);
    assign bus.pc        = pc;
    assign bus.out_data  = out_data;
    assign bus.out_valid = out_valid;

    logic [DW-1:0] addend;
    logic [DW:0]   sum;
    logic [DW-1:0] res;
    logic          c_new, wr_acc, wr_flags, take;

    assign addend = (opcode == OP_ADDI) ? k : dr;
    assign sum    = {1'b0, acc} + {1'b0, addend};
    assign take   = (opcode == OP_JMP) || ((opcode == OP_JZ) && flag_z) ||
                    ((opcode == OP_JC) && flag_c);

    always_comb begin
        res      = acc;
        c_new    = flag_c;
        wr_acc   = 1'b0;
        wr_flags = 1'b0;
        case (opcode)
            OP_LDI:          begin res = k;  wr_acc = 1'b1; end
            OP_LDM:          begin res = dr; wr_acc = 1'b1; end
            OP_ADDI, OP_ADDM: begin
                res = sum[DW-1:0]; c_new = sum[DW]; wr_acc = 1'b1; wr_flags = 1'b1;
            end
            OP_SUBM: begin
                res = acc - dr; c_new = (acc < dr); wr_acc = 1'b1; wr_flags = 1'b1;
            end
            OP_ANDM: begin res = acc & dr; c_new = 1'b0; wr_acc = 1'b1; wr_flags = 1'b1; end
            OP_ORM:  begin res = acc | dr; c_new = 1'b0; wr_acc = 1'b1; wr_flags = 1'b1; end
            OP_XORM: begin res = acc ^ dr; c_new = 1'b0; wr_acc = 1'b1; wr_flags = 1'b1; end
            OP_SHL: begin
                res = {acc[DW-2:0], 1'b0}; c_new = acc[DW-1]; wr_acc = 1'b1; wr_flags = 1'b1;
            end
            OP_NOP, OP_STM, OP_JMP, OP_JZ, OP_JC, OP_OUT, OP_HLT: ;
            default: ;
        endcase
    end

    // Program memory has no reset; only accepted load beats write it.
    always_ff @(posedge clk) begin
        if (load_fire && !rs)
            pmem[load_addr] <= bus.ld_data;
    end

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            state     <= S_LOAD;
            load_addr <= '0;
            pc        <= '0;
            acc       <= '0;
            dr        <= '0;
            ir        <= '0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < 2**DAW; i++)
                dmem[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (load_done) begin
                        load_addr <= '0;
                        pc        <= '0;
                        acc       <= '0;
                        dr        <= '0;
                        ir        <= '0;
                        flag_n    <= 1'b0;
                        flag_c    <= 1'b0;
                        flag_z    <= 1'b0;
                        state     <= S_FETCH;
                    end else if (load_fire) begin
                        load_addr <= load_addr + PAW'(1);
                    end
                end
                S_FETCH: begin
                    ir    <= pmem[pc];
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    dr    <= dmem[daddr];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= (opcode == OP_HLT) ? S_HALT : S_FETCH;
                    pc    <= take ? k[PAW-1:0] : pc + PAW'(1);
                    if (wr_acc)
                        acc <= res;
                    if (wr_flags) begin
                        flag_c <= c_new;
                        flag_z <= (res == '0);
                        flag_n <= res[DW-1];
                    end
                    if (opcode == OP_STM)
                        dmem[daddr] <= acc;
                    if (opcode == OP_OUT) begin
                        out_data  <= acc;
                        out_valid <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (bus.reload) begin
                        state     <= S_LOAD;
                        load_addr <= '0;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end
endmodule
